seq_div_32by16: RTL and testbench
=================================

# seq_div_32by16

Iterative radix-2 restoring divider: the inverse operation to the team's 16×16 Dadda multiplier. Accepts a 32-bit dividend and a 16-bit divisor over a valid/ready handshake. Produces a 32-bit quotient and 16-bit remainder one quotient bit per cycle. Sits beside the multiplier in the arithmetic datapath and is used to recover operands from products, e.g. product / B = A, remainder 0.

## Interface
Parameters:
- `WN`, default 32: dividend and quotient width.
- `WD`, default 16: divisor and remainder width. `WD` must be ≤ `WN`.

Ports (clock and reset first):
- `clk`, input, 1: single clock; all state on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: operands present.
- `in_ready`, output, 1: block can accept operands; high only in IDLE.
- `N`, input, WN: dividend.
- `D`, input, WD: divisor.
- `out_valid`, output, 1: result present; held until taken.
- `out_ready`, input, 1: consumer takes the result.
- `Q`, output, WN: quotient.
- `R`, output, WD: remainder.
- `div_by_zero`, output, 1: qualifies the current result as a divide by zero.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, latch `N` into the quotient/shift register and `D` into the divisor register, and clear the partial remainder (WD+1 bits).
  - If `D`==0: go to DONE with `div_by_zero`=1, `Q`=all ones, `R`=`N[WD-1:0]`.
  - Otherwise: set iteration counter = WN-1 and go to CALC.
- CALC, one step per cycle:
  - Shift {rem, quo} left by 1, feeding the dividend MSB into the remainder LSB.
  - trial = rem − divisor.
  - If trial is non-negative: rem = trial and quotient LSB = 1. Otherwise: restore, quotient LSB = 0.
  - When the counter reaches 0 after its step, go to DONE. Otherwise decrement the counter.
- DONE:
  - `out_valid`=1; `Q`/`R`/`div_by_zero` stable.
  - On `out_ready`, go to IDLE.
  - `in_ready` stays 0 in DONE, so there is no overlap of accept and deliver in the same cycle.
- Width rules:
  - The partial remainder is WD+1 bits so the trial subtract never overflows.
  - `R` is the low WD bits and is always < D.
  - The quotient is full WN bits, so no quotient overflow is possible.
- Inputs `N`/`D` are ignored outside the accept cycle and may change freely during CALC.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `Q`=0, `R`=0, `div_by_zero`=0, counter=0.
- Reset asserted mid-CALC or mid-DONE aborts immediately. The result is lost and the outputs return to their reset values asynchronously.
- Latency, with the accept at rising edge k:
  - Normal divide: WN steps on edges k+1 … k+WN. `out_valid` is high after edge k+WN (32 cycles for default widths).
  - Divide by zero: `out_valid` is high after edge k, i.e. the next cycle.
- Throughput: one operation per WN+2 cycles minimum (accept, WN steps, deliver).
- Backpressure: with `out_ready`=0, DONE holds indefinitely and the outputs do not change.
- `out_valid` falls on the edge after the cycle in which `out_ready`=1.
- `in_ready` rises on that same edge.

## Structure
- Shared package `arith_pkg`, holding:
  - default widths `WN`/`WD`;
  - state enum {IDLE, CALC, DONE};
  - constant for the divide-by-zero quotient pattern.
- Sub-module `div_step`: purely combinational single restoring step.
  - Inputs: rem[WD:0], next dividend bit, divisor.
  - Outputs: new rem, quotient bit.
  - Instantiated once; the top-level module holds the registers, counter and FSM.

## Test plan
- 100 / 7 → `Q`=14, `R`=2, `div_by_zero`=0. `out_valid` exactly 32 cycles after the accept edge.
- Round-trip with the multiplier: N=0x06260060 (0x1234×0x5678), D=0x5678 → `Q`=0x00001234, `R`=0.
- 0xFFFFFFFF / 0xFFFF → `Q`=0x00010001, `R`=0. Then 5 / 9 → `Q`=0, `R`=5.
- D=0, N=0xDEADBEEF → `div_by_zero`=1, `Q`=0xFFFFFFFF, `R`=0xBEEF. `out_valid` one cycle after accept.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → outputs stable, `in_ready`=0, a new `in_valid` is not accepted. Releasing `out_ready` returns to IDLE.
- Drop `rst_n` 12 cycles into CALC → `out_valid`/`Q`/`R` go to 0 immediately and `in_ready`=1. A fresh 100 / 7 afterwards gives 14 r 2.

Source files
------------

// File: rtl/arith_pkg.sv
// arith_pkg: shared widths, FSM states and constants for the arithmetic datapath
package arith_pkg;
  localparam int DEF_WN = 32;
  localparam int DEF_WD = 16;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  // Every quotient bit takes this value when dividing by zero (quotient = all ones).
  localparam logic DBZ_Q_BIT = 1'b1;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step
// ports: rem (partial remainder, WD+1), din (next dividend bit), dvs (divisor) -> rem_nxt, qbit
module div_step #(
  parameter int WD = 16
) (
  input  logic [WD:0]   rem,
  input  logic          din,
  input  logic [WD-1:0] dvs,
  output logic [WD:0]   rem_nxt,
  output logic          qbit
);
  logic [WD+1:0] trial;
  // rem < dvs always holds, so the shifted value fits in WD+1 bits and trial's MSB is the sign.
  assign trial   = {rem, din} - {2'b00, dvs};
  assign qbit    = ~trial[WD+1];
  assign rem_nxt = qbit ? trial[WD:0] : {rem[WD-1:0], din};
endmodule

// File: rtl/seq_div_32by16.sv
// seq_div_32by16: iterative radix-2 restoring divider, one quotient bit per cycle
// ports: clk, rst_n (async, active-low); in_valid/in_ready with N (dividend), D (divisor);
//        out_valid/out_ready with Q (quotient), R (remainder), div_by_zero
module seq_div_32by16
  import arith_pkg::*;
#(
  parameter int WN = DEF_WN,
  parameter int WD = DEF_WD
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WN-1:0] N,
  input  logic [WD-1:0] D,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WN-1:0] Q,
  output logic [WD-1:0] R,
  output logic          div_by_zero
);
  localparam int CW = $clog2(WN);
  state_t        state, state_nxt;
  logic [WN-1:0] quo;
  logic [WD:0]   rem, rem_nxt;
  logic [WD-1:0] dvs;
  logic [CW-1:0] cnt;
  logic          dbz, qbit, accept, dzero;
  assign accept      = in_valid && in_ready;
  assign dzero       = (D == '0);
  assign Q           = quo;
  assign R           = rem[WD-1:0];
  assign div_by_zero = dbz;
  div_step #(.WD(WD)) u_step (
    .rem    (rem),
    .din    (quo[WN-1]),
    .dvs    (dvs),
    .rem_nxt(rem_nxt),
    .qbit   (qbit)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    state_nxt = (state == IDLE) ? (accept ? (dzero ? DONE : CALC) : IDLE)
              : (state == CALC) ? ((cnt == '0) ? DONE : CALC)
              : (out_ready ? IDLE : DONE);
  end
  // The dividend shifts out of quo's MSB as quotient bits shift into its LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
      dbz <= 1'b0;
    end else if (accept) begin
      dvs <= D;
      dbz <= dzero;
      quo <= dzero ? {WN{DBZ_Q_BIT}} : N;
      rem <= dzero ? {1'b0, N[WD-1:0]} : '0;
      cnt <= CW'(WN - 1);
    end else if (state == CALC) begin
      quo <= {quo[WN-2:0], qbit};
      rem <= rem_nxt;
      cnt <= (cnt == '0) ? cnt : cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_seq_div_32by16.sv
// tb_seq_div_32by16: directed self-checking bench for seq_div_32by16
module tb_seq_div_32by16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] N = '0;
  logic [15:0] D = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] Q;
  logic [15:0] R;
  logic        div_by_zero;
  int          checks = 0;
  int          errors = 0;
  int          lat;
  logic [31:0] q_hold;
  logic [15:0] r_hold;
  always #5 clk = ~clk;
  seq_div_32by16 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .N          (N),
    .D          (D),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Q          (Q),
    .R          (R),
    .div_by_zero(div_by_zero)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Accept one operand pair, then count edges after the accept edge until out_valid.
  task automatic start(input logic [31:0] n, input logic [15:0] d, output int cyc);
    @(negedge clk);
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    N = n;
    D = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    N = $urandom;
    D = 16'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_after_take", 64'(out_valid), 64'd0);
    chk("in_ready_after_take", 64'(in_ready), 64'd1);
  endtask
  task automatic divide(input string tag, input logic [31:0] n, input logic [15:0] d,
                        input logic [31:0] eq, input logic [15:0] er, input logic ez, input int elat);
    start(n, d, lat);
    chk({tag, "_latency"}, 64'(lat), 64'(elat));
    chk({tag, "_Q"}, 64'(Q), 64'(eq));
    chk({tag, "_R"}, 64'(R), 64'(er));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
    take();
  endtask
  initial begin
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_Q", 64'(Q), 64'd0);
    chk("rst_R", 64'(R), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    divide("100div7", 32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 32);
    divide("roundtrip", 32'h0626_0060, 16'h5678, 32'h0000_1234, 16'h0, 1'b0, 32);
    divide("maxdiv", 32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'h0, 1'b0, 32);
    divide("5div9", 32'd5, 16'd9, 32'd0, 16'd5, 1'b0, 32);
    divide("divzero", 32'hDEAD_BEEF, 16'h0, 32'hFFFF_FFFF, 16'hBEEF, 1'b1, 0);
    divide("after_dbz", 32'd1000, 16'd10, 32'd100, 16'd0, 1'b0, 32);
    // Backpressure: result must hold while out_ready stays low and new operands wait.
    start(32'd12345, 16'd100, lat);
    chk("bp_Q", 64'(Q), 64'd123);
    chk("bp_R", 64'(R), 64'd45);
    q_hold = Q;
    r_hold = R;
    in_valid = 1'b1;
    N = 32'd77;
    D = 16'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_Q_stable", 64'(Q), 64'(q_hold));
      chk("bp_R_stable", 64'(R), 64'(r_hold));
    end
    in_valid = 1'b0;
    take();
    chk("bp_not_accepted_Q", 64'(Q), 64'd123);
    // Reset 12 steps into CALC aborts asynchronously.
    @(negedge clk);
    in_valid = 1'b1;
    N = 32'hDEAD_BEEF;
    D = 16'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_Q", 64'(Q), 64'd0);
    chk("abort_R", 64'(R), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    divide("post_abort", 32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 32);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
